alu_serial_ctrl: RTL and testbench

Bit-serial 32-bit ALU sequencer built around a single 1-bit ALU slice (A/B invert, AND/OR/add/less select, carry in/out). It accepts one 32-bit operation per start handshake and walks the slice LSB→MSB, one bit per clock, holding the carry in a register between bits. It produces the 32-bit result plus zero, carry-out and overflow flags, so the team can use one slice in place of a 32-slice ripple array.

---
 rtl/alu_serial_ctrl_if.sv | 24 ++
 rtl/alu_serial_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial ALU sequencer.
// The master drives requests and operands; the slave (sequencer) returns the result and flags.
interface alu_serial_ctrl_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;

  modport master (
    output start_i, src1_i, src2_i, ctrl_i,
    input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );

  modport slave (
    input  start_i, src1_i, src2_i, ctrl_i,
    output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit ALU slice walked LSB to MSB, one bit per clock,
// with the carry held in a register between bits; reports result, zero, carry-out and overflow.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  alu_serial_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic [1:0] op;
    logic       legal;
  } slice_ctl_t;

  function automatic slice_ctl_t decode(input logic [3:0] code);
    slice_ctl_t c;
    c = '{ainv: 1'b0, binv: 1'b0, op: 2'b00, legal: 1'b1};
    case (code)
      OP_AND:         c.op = 2'b00;
      OP_OR:          c.op = 2'b01;
      OP_ADD:         c.op = 2'b10;
      OP_SUB, OP_SLT: begin c.binv = 1'b1; c.op = 2'b10; end
      OP_NOR:         begin c.ainv = 1'b1; c.binv = 1'b1; c.op = 2'b00; end
      default:        c.legal = 1'b0;
    endcase
    return c;
  endfunction

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, shreg;
  logic [3:0]       ctrl_q;
  logic [CW-1:0]    cnt;
  logic             carry, carry_in31;
  slice_ctl_t       ctl, ctl_in;

  logic             a_bit, b_bit, sum_bit, cout_bit, res_bit;
  logic             ovf;
  logic [WIDTH-1:0] fin_result;
  logic             fin_cout, fin_ovf;

  assign ctl    = decode(ctrl_q);
  assign ctl_in = decode(bus.ctrl_i);

  // One ALU slice; the 'less' input is tied low, so op 11 yields 0.
  always_comb begin
    a_bit    = a_q[cnt] ^ ctl.ainv;
    b_bit    = b_q[cnt] ^ ctl.binv;
    sum_bit  = a_bit ^ b_bit ^ carry;
    cout_bit = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    case (ctl.op)
      2'b00:   res_bit = a_bit & b_bit;
      2'b01:   res_bit = a_bit | b_bit;
      2'b10:   res_bit = sum_bit;
      default: res_bit = 1'b0;
    endcase
  end

  // Final result and flags, evaluated while in FIN once all bits are in the shift register.
  always_comb begin
    ovf        = carry_in31 ^ carry;
    fin_result = shreg;
    fin_cout   = 1'b0;
    fin_ovf    = 1'b0;
    if (!ctl.legal) begin
      fin_result = '0;
    end else if (ctrl_q == OP_SLT) begin
      fin_result = {{(WIDTH-1){1'b0}}, shreg[WIDTH-1] ^ ovf};
    end else if (ctrl_q == OP_ADD || ctrl_q == OP_SUB) begin
      fin_cout = carry;
      fin_ovf  = ovf;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = RUN;
      RUN:     if (cnt == LAST_BIT) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      a_q            <= '0;
      b_q            <= '0;
      ctrl_q         <= '0;
      shreg          <= '0;
      cnt            <= '0;
      carry          <= 1'b0;
      carry_in31     <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.result_o   <= '0;
      bus.zero_o     <= 1'b0;
      bus.cout_o     <= 1'b0;
      bus.overflow_o <= 1'b0;
    end else begin
      bus.done_o <= (state == FIN);
      case (state)
        IDLE: if (bus.start_i) begin
          a_q    <= bus.src1_i;
          b_q    <= bus.src2_i;
          ctrl_q <= bus.ctrl_i;
          cnt    <= '0;
          carry  <= ctl_in.binv;
        end
        RUN: begin
          shreg <= {res_bit, shreg[WIDTH-1:1]};
          carry <= cout_bit;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) carry_in31 <= carry;
        end
        FIN: begin
          bus.result_o   <= fin_result;
          bus.zero_o     <= (fin_result == '0);
          bus.cout_o     <= fin_cout;
          bus.overflow_o <= fin_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o = (state != IDLE);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: a cycle-level latency model predicts done/busy and
// arithmetic results every cycle, and directed vectors pin the model with literal expectations.
module tb_alu_serial_ctrl;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_serial_ctrl_if #(.WIDTH(32)) bus ();

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
  } outs_t;

  // Architectural meaning of each op code, from wide arithmetic rather than bit iteration.
  function automatic outs_t model_calc(input logic [3:0] ctrl, input logic [31:0] a,
                                       input logic [31:0] b);
    outs_t o;
    logic [32:0] s;
    o = '0;
    case (ctrl)
      4'b0000: o.result = a & b;
      4'b0001: o.result = a | b;
      4'b1100: o.result = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        o.result = s[31:0];
        o.cout   = s[32];
        o.ovf    = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.result = s[31:0];
        o.cout   = s[32];
        o.ovf    = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'b0111: o.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: o.result = 32'd0;
    endcase
    o.zero = (o.result == 32'd0);
    return o;
  endfunction

  // Latency model: accept in idle, deliver 33 edges later, hold outputs until the next delivery.
  bit    m_busy;
  bit    m_done;
  int    m_left;
  outs_t m_pend;
  outs_t m_out;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0; m_pend = '0; m_out = '0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (bus.start_i) begin
          m_busy = 1;
          m_left = 33;
          m_pend = model_calc(bus.ctrl_i, bus.src1_i, bus.src2_i);
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          m_out  = m_pend;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    check("cyc_busy",   32'(bus.busy_o),     32'(m_busy));
    check("cyc_done",   32'(bus.done_o),     32'(m_done));
    check("cyc_result", bus.result_o,        m_out.result);
    check("cyc_zero",   32'(bus.zero_o),     32'(m_out.zero));
    check("cyc_cout",   32'(bus.cout_o),     32'(m_out.cout));
    check("cyc_ovf",    32'(bus.overflow_o), 32'(m_out.ovf));
  end

  task automatic run_op(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez,
                        input logic ec, input logic ev);
    int n;
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.ctrl_i = ctrl; bus.src1_i = a; bus.src2_i = b;
    @(negedge clk_i);
    n = 1;
    bus.start_i = 1'b0; bus.src1_i = ~a; bus.src2_i = $urandom; bus.ctrl_i = 4'b1111;
    while (!bus.done_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_latency"}, 32'(n - 1), 32'd33);
    check({name, "_result"},  bus.result_o, er);
    check({name, "_zero"},    32'(bus.zero_o), 32'(ez));
    check({name, "_cout"},    32'(bus.cout_o), 32'(ec));
    check({name, "_ovf"},     32'(bus.overflow_o), 32'(ev));
  endtask

  initial begin
    int n, dones, t1, t2;
    bit drop;
    bus.start_i = 1'b0; bus.src1_i = '0; bus.src2_i = '0; bus.ctrl_i = '0;
    #1;
    check("reset_busy",   32'(bus.busy_o), 32'd0);
    check("reset_done",   32'(bus.done_o), 32'd0);
    check("reset_result", bus.result_o,    32'd0);
    check("reset_zero",   32'(bus.zero_o), 32'd0);
    #20 rst_n = 1'b1;

    run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1);
    run_op("sub_zero", 4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 1, 0);
    run_op("sub_neg",  4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0, 0);
    run_op("slt_ovf",  4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 0, 0);
    run_op("slt_min",  4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0);
    run_op("and",      4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0);
    run_op("or",       4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0);
    run_op("nor",      4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 0, 0, 0);
    run_op("illegal",  4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000, 1, 0, 0);
    run_op("add_cout", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0, 1, 0);

    // Start pulse during RUN must be ignored.
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.ctrl_i = 4'b0010; bus.src1_i = 32'd1; bus.src2_i = 32'd2;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    dones = 0;
    for (n = 1; n < 60; n++) begin
      if (n == 10) begin bus.start_i = 1'b1; bus.src1_i = 32'd100; end
      if (n == 11) bus.start_i = 1'b0;
      @(negedge clk_i);
      if (bus.done_o) begin
        dones++;
        check("ignore_result", bus.result_o, 32'd3);
      end
    end
    check("ignore_dones", 32'(dones), 32'd1);

    // Start held through done: second op accepted in the done cycle.
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.ctrl_i = 4'b0010; bus.src1_i = 32'd10; bus.src2_i = 32'd20;
    t1 = 0; t2 = 0; drop = 0;
    for (n = 1; n < 120 && t2 == 0; n++) begin
      @(negedge clk_i);
      if (n == 1) begin bus.ctrl_i = 4'b0110; bus.src1_i = 32'd50; bus.src2_i = 32'd8; end
      if (drop) begin bus.start_i = 1'b0; drop = 0; end
      if (bus.done_o) begin
        if (t1 == 0) begin
          t1 = n; drop = 1;
          check("b2b_first_result", bus.result_o, 32'd30);
        end else begin
          t2 = n;
          check("b2b_second_result", bus.result_o, 32'd42);
        end
      end
    end
    check("b2b_first_latency", 32'(t1 - 1), 32'd33);
    check("b2b_spacing", 32'(t2 - t1), 32'd34);

    // Asynchronous reset partway through an ADD.
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.ctrl_i = 4'b0010; bus.src1_i = 32'h1234_0000; bus.src2_i = 32'h0000_5678;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (16) @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(bus.busy_o),     32'd0);
    check("abort_done",   32'(bus.done_o),     32'd0);
    check("abort_result", bus.result_o,        32'd0);
    check("abort_zero",   32'(bus.zero_o),     32'd0);
    check("abort_cout",   32'(bus.cout_o),     32'd0);
    check("abort_ovf",    32'(bus.overflow_o), 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.done_o) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op("after_reset", 4'b0010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0, 0);

    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
